// File: rtl/sext_accum_pkg.sv
// Shared types and constant helpers for the sign-extending frame accumulator.
// Width-generic helpers work on a 64-bit container; callers slice to their own width.
package sext_accum_pkg;

   typedef enum logic {
      ACC = 1'b0,
      OUT = 1'b1
   } state_t;

   localparam int MAXW = 64;

   // Largest positive n-bit two's-complement value, right-aligned in MAXW bits.
   function automatic logic [MAXW-1:0] max_val(input logic [6:0] n);
      return (64'd1 << (n - 7'd1)) - 64'd1;
   endfunction

   // Most negative n-bit two's-complement value, right-aligned in MAXW bits.
   function automatic logic [MAXW-1:0] min_val(input logic [6:0] n);
      return 64'd1 << (n - 7'd1);
   endfunction

   // An (n+1)-bit sum of two sign-extended n-bit operands overflowed n bits
   // exactly when its top two bits disagree.
   function automatic logic sum_ovf(input logic [MAXW:0] s, input logic [6:0] n);
      return s[n] != s[n - 7'd1];
   endfunction

endpackage

// File: rtl/sext_accum_sign_extend.sv
// Purely combinational K-to-N signed widening.
module sign_extend #(
   parameter int K = 8,
   parameter int N = 16
) (
   input  logic [K-1:0] narrow,
   output logic [N-1:0] wide
);

   assign wide = {{(N-K){narrow[K-1]}}, narrow};

endmodule

// File: rtl/sext_accum.sv
// Sums L sign-extended K-bit samples into one N-bit frame result with optional
// clamping; valid/ready on both sides, never accepting input while a result is pending.
module sext_accum
   import sext_accum_pkg::*;
#(
   parameter int K   = 8,
   parameter int N   = 16,
   parameter int L   = 4,
   parameter bit SAT = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [K-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_data,
   output logic         o_ovf
);

   localparam int CW = (L > 1) ? $clog2(L) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

   localparam logic [MAXW-1:0] MAX_W = max_val(7'(N));
   localparam logic [MAXW-1:0] MIN_W = min_val(7'(N));
   localparam logic signed [N-1:0] ACC_MAX = MAX_W[N-1:0];
   localparam logic signed [N-1:0] ACC_MIN = MIN_W[N-1:0];

   state_t state, state_nxt;

   logic [CW-1:0]         cnt;
   logic signed [N-1:0]   acc;
   logic                  ovf;

   logic [N-1:0]          x_wide;
   logic signed [N-1:0]   x_p0;
   logic signed [N:0]     sum_p0;
   logic                  step_ovf_p0;
   logic signed [N-1:0]   acc_nxt_p0;
   logic                  in_acc;
   logic                  out_acc;

   // Clamp toward the sign of the true sum only when enabled; otherwise wrap.
   function automatic logic signed [N-1:0] sat_step(input logic signed [N:0] s,
                                                    input logic            over);
      if (SAT && over)
         return s[N] ? ACC_MIN : ACC_MAX;
      else
         return s[N-1:0];
   endfunction

   sign_extend #(
      .K(K),
      .N(N)
   ) u_sext (
      .narrow(i_data),
      .wide  (x_wide)
   );

   assign x_p0        = x_wide;
   assign sum_p0      = {acc[N-1], acc} + {x_p0[N-1], x_p0};
   assign step_ovf_p0 = sum_ovf({{(MAXW-N){1'b0}}, sum_p0}, 7'(N));
   assign acc_nxt_p0  = sat_step(sum_p0, step_ovf_p0);

   assign o_ready = (state == ACC);
   assign o_valid = (state == OUT);
   assign in_acc  = i_valid && o_ready;
   assign out_acc = o_valid && i_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         state <= ACC;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC: if (in_acc && (cnt == CNT_LAST)) state_nxt = OUT;
         OUT: if (out_acc) state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   // Sum stage -> accumulator and frame output registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt    <= '0;
         acc    <= '0;
         ovf    <= 1'b0;
         o_data <= '0;
         o_ovf  <= 1'b0;
      end else if (in_acc) begin
         acc <= acc_nxt_p0;
         ovf <= ovf | step_ovf_p0;
         if (cnt == CNT_LAST) begin
            cnt    <= '0;
            o_data <= acc_nxt_p0;
            o_ovf  <= ovf | step_ovf_p0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else if (out_acc) begin
         acc <= '0;
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sext_accum.sv
// Scoreboard bench: three accumulators (N=9 clamp, N=9 wrap, N=10 clamp) share one stimulus stream.
module tb_sext_accum;

   typedef struct {
      longint data;
      bit     ovf;
   } exp_t;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_valid = 1'b0;
   logic       i_ready = 1'b0;
   logic [7:0] i_data = '0;

   logic       sat_rdy, sat_vld, sat_ovf;
   logic [8:0] sat_data;
   logic       wrp_rdy, wrp_vld, wrp_ovf;
   logic [8:0] wrp_data;
   logic       w10_rdy, w10_vld, w10_ovf;
   logic [9:0] w10_data;

   exp_t q_sat[$];
   exp_t q_wrp[$];
   exp_t q_w10[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   sext_accum #(.K(8), .N(9), .L(4), .SAT(1'b1)) u_sat (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(sat_rdy),
      .i_data(i_data), .o_valid(sat_vld), .i_ready(i_ready), .o_data(sat_data), .o_ovf(sat_ovf)
   );

   sext_accum #(.K(8), .N(9), .L(4), .SAT(1'b0)) u_wrp (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(wrp_rdy),
      .i_data(i_data), .o_valid(wrp_vld), .i_ready(i_ready), .o_data(wrp_data), .o_ovf(wrp_ovf)
   );

   sext_accum #(.K(8), .N(10), .L(4), .SAT(1'b1)) u_w10 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(w10_rdy),
      .i_data(i_data), .o_valid(w10_vld), .i_ready(i_ready), .o_data(w10_data), .o_ovf(w10_ovf)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Integer reference: add, then clamp or wrap back into n-bit range.
   function automatic exp_t model(input int n, input bit sat, input int s[4]);
      longint mx, mn, acc, sum;
      exp_t r;
      mx    = (longint'(1) << (n - 1)) - 1;
      mn    = -(longint'(1) << (n - 1));
      acc   = 0;
      r.ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sum = acc + longint'(s[i]);
         if (sum > mx) begin
            r.ovf = 1'b1;
            acc   = sat ? mx : sum - (mx - mn + 1);
         end else if (sum < mn) begin
            r.ovf = 1'b1;
            acc   = sat ? mn : sum + (mx - mn + 1);
         end else begin
            acc = sum;
         end
      end
      r.data = acc;
      return r;
   endfunction

   task automatic push_exp(input int s[4]);
      q_sat.push_back(model(9, 1'b1, s));
      q_wrp.push_back(model(9, 1'b0, s));
      q_w10.push_back(model(10, 1'b1, s));
   endtask

   task automatic send_sample(input int v);
      i_valid = 1'b1;
      i_data  = 8'(v);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic send_frame(input int s[4]);
      for (int i = 0; i < 4; i++) send_sample(s[i]);
      push_exp(s);
   endtask

   task automatic wait_valid(input string tag);
      int t;
      t = 0;
      while (!sat_vld && t < 20) begin
         @(posedge i_clk);
         #1;
         t++;
      end
      chk({tag, " sat valid"}, longint'(sat_vld), 1);
      chk({tag, " wrap valid"}, longint'(wrp_vld), 1);
      chk({tag, " n10 valid"}, longint'(w10_vld), 1);
   endtask

   task automatic check_frame(input string tag);
      exp_t e;
      wait_valid(tag);
      if (q_sat.size() > 0 && q_wrp.size() > 0 && q_w10.size() > 0) begin
         e = q_sat.pop_front();
         chk({tag, " sat data"}, longint'($signed(sat_data)), e.data);
         chk({tag, " sat ovf"}, longint'(sat_ovf), longint'(e.ovf));
         e = q_wrp.pop_front();
         chk({tag, " wrap data"}, longint'($signed(wrp_data)), e.data);
         chk({tag, " wrap ovf"}, longint'(wrp_ovf), longint'(e.ovf));
         e = q_w10.pop_front();
         chk({tag, " n10 data"}, longint'($signed(w10_data)), e.data);
         chk({tag, " n10 ovf"}, longint'(w10_ovf), longint'(e.ovf));
      end else begin
         chk({tag, " scoreboard empty"}, 0, 1);
      end
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      chk({tag, " valid drops"}, longint'(sat_vld), 0);
      chk({tag, " ready returns"}, longint'(sat_rdy), 1);
   endtask

   initial begin
      int   s[4];
      logic [7:0] b;
      exp_t held;

      repeat (2) @(posedge i_clk);
      #1;
      chk("reset o_ready", longint'(sat_rdy), 1);
      chk("reset o_valid", longint'(sat_vld), 0);
      chk("reset o_data", longint'(sat_data), 0);
      chk("reset o_ovf", longint'(sat_ovf), 0);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      send_frame('{-1, -2, 3, 0});
      check_frame("sext small");
      send_frame('{-128, 0, 0, 0});
      check_frame("sext 0x80");
      send_frame('{127, 127, 127, 127});
      check_frame("pos ovf");
      send_frame('{-128, -128, -128, -128});
      check_frame("neg bound");

      for (int i = 0; i < 3; i++) send_sample(127);
      chk("clamp mid acc", longint'($signed(u_sat.acc)), 255);
      send_sample(-128);
      push_exp('{127, 127, 127, -128});
      check_frame("clamp recover");

      send_frame('{5, 6, 7, -100});
      wait_valid("bp");
      held = (q_sat.size() > 0) ? q_sat[0] : '{data: 0, ovf: 1'b0};
      for (int c = 0; c < 5; c++) begin
         i_valid = 1'b1;
         i_data  = 8'h55;
         @(posedge i_clk);
         #1;
         chk("bp valid held", longint'(sat_vld), 1);
         chk("bp ready low", longint'(sat_rdy), 0);
         chk("bp data stable", longint'($signed(sat_data)), held.data);
         chk("bp ovf stable", longint'(sat_ovf), longint'(held.ovf));
      end
      i_valid = 1'b0;
      check_frame("bp release");
      send_frame('{10, 20, 30, 40});
      check_frame("after bp");

      send_sample(9);
      send_sample(9);
      i_rst_n = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      chk("mid rst o_valid", longint'(sat_vld), 0);
      chk("mid rst o_data", longint'(sat_data), 0);
      chk("mid rst o_ready", longint'(sat_rdy), 1);
      send_frame('{1, 1, 1, 1});
      check_frame("post rst");

      send_frame('{50, 50, 50, 50});
      chk("out rst pre valid", longint'(sat_vld), 1);
      i_rst_n = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      chk("out rst o_valid", longint'(sat_vld), 0);
      chk("out rst o_ovf", longint'(sat_ovf), 0);
      void'(q_sat.pop_front());
      void'(q_wrp.pop_front());
      void'(q_w10.pop_front());

      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 4; i++) begin
            b    = 8'($urandom);
            s[i] = int'($signed(b));
         end
         send_frame(s);
         check_frame("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
